fir_da_lut_loader: RTL and testbench

Upstream companion of `fir_filter`. It holds the 64 raw FIR coefficients and expands them into the 2048-entry distributed-arithmetic partial-sum table. It streams that table into `fir_filter` over its `CIN`/`CADDR`/`CLOAD` load port, one entry per `clk_slow` cycle, in place of an external precompute.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_da_lut_loader_if.sv | 26 ++
 rtl/da_group_sum.sv | 34 +++
 rtl/fir_da_lut_loader.sv | 115 +++++++++++
 tb/tb_fir_da_lut_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared widths and state encoding for the DA FIR coefficient path.
// Used by the table loader and by fir_filter's load port.
package fir_pkg;

  localparam int COEF_W    = 16;
  localparam int NTAPS     = 64;
  localparam int GRP       = 8;
  localparam int LUT_W     = 20;
  localparam int ADDR_W    = 11;
  localparam int LUT_DEPTH = 2048;
  localparam int NGRP      = NTAPS / GRP;
  localparam int GRP_W     = $clog2(NGRP);
  localparam int COEF_AW   = $clog2(NTAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_da_lut_loader_if.sv
// Coefficient write port, start/status and table load port of the loader.
// The master side is the host/filter; the slave side is the loader itself.
interface fir_da_lut_loader_if;
  import fir_pkg::*;

  logic                coef_we;
  logic [COEF_AW-1:0]  coef_addr;
  logic [COEF_W-1:0]   coef_in;
  logic                start;
  logic [LUT_W-1:0]    CIN;
  logic [ADDR_W-1:0]   CADDR;
  logic                CLOAD;
  logic                busy;
  logic                done;

  modport master (
    output coef_we, coef_addr, coef_in, start,
    input  CIN, CADDR, CLOAD, busy, done
  );

  modport slave (
    input  coef_we, coef_addr, coef_in, start,
    output CIN, CADDR, CLOAD, busy, done
  );

endinterface

// File: rtl/da_group_sum.sv
// Conditional sum of one 8-tap DA group: bit b of the pattern selects coef b.
// Purely combinational; zero-extended so 8 x max coefficient cannot overflow.
module da_group_sum
  import fir_pkg::*;
(
  input  logic [GRP-1:0][COEF_W-1:0] i_coef,
  input  logic [GRP-1:0]             i_pat,
  output logic [LUT_W-1:0]           o_sum
);

  logic [GRP-1:0][LUT_W-1:0] w_term;

  always_comb begin
    w_term = '0;
    for (int b = 0; b < GRP; b++) begin
      w_term[b] = i_pat[b] ? LUT_W'(i_coef[b]) : '0;
    end
  end

  // Balanced tree keeps the critical path at three adder levels.
  logic [LUT_W-1:0] w_l1 [4];
  logic [LUT_W-1:0] w_l2 [2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_l1[i] = w_term[2*i] + w_term[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
    end
    o_sum = w_l2[0] + w_l2[1];
  end

endmodule

// File: rtl/fir_da_lut_loader.sv
// Holds 64 coefficients and streams the 2048-entry DA partial-sum table, one
// entry per clk_slow cycle; each entry is registered one cycle after its address.
module fir_da_lut_loader
  import fir_pkg::*;
(
  input  logic                 clk_slow,
  input  logic                 resetn,
  fir_da_lut_loader_if.slave   bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic [COEF_W-1:0]          r_coef [NTAPS];
  logic [ADDR_W-1:0]          r_cnt;
  logic [LUT_W-1:0]           r_cin;
  logic [ADDR_W-1:0]          r_caddr;
  logic                       r_cload;
  logic                       r_done;

  logic                       w_coef_wr;
  logic                       w_last_out;
  logic [GRP-1:0][COEF_W-1:0] w_grp_coef;
  logic [LUT_W-1:0]           w_entry;

  // Writes are locked out while a table is streaming so it stays self-consistent.
  assign w_coef_wr  = bus.coef_we && (r_state == IDLE);
  assign w_last_out = r_cload && (r_caddr == ADDR_W'(LUT_DEPTH - 1));

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_coef[i] <= '0;
      end
    end else if (w_coef_wr) begin
      r_coef[bus.coef_addr] <= bus.coef_in;
    end
  end

  always_comb begin
    w_grp_coef = '0;
    for (int b = 0; b < GRP; b++) begin
      w_grp_coef[b] = r_coef[{r_cnt[ADDR_W-1:GRP], GRP_W'(b)}];
    end
  end

  da_group_sum u_group_sum (
    .i_coef (w_grp_coef),
    .i_pat  (r_cnt[GRP-1:0]),
    .o_sum  (w_entry)
  );

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // GEN ends on the cycle the last entry sits on the port, so done follows it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = GEN;
      GEN:     if (w_last_out) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_cin   <= '0;
      r_caddr <= '0;
      r_cload <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cload <= 1'b0;
          if (bus.start) r_cnt <= '0;
        end
        GEN: begin
          if (w_last_out) begin
            r_cload <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cin   <= w_entry;
            r_caddr <= r_cnt;
            r_cload <= 1'b1;
            r_cnt   <= r_cnt + ADDR_W'(1);
          end
        end
        DONE:    r_cload <= 1'b0;
        default: r_cload <= 1'b0;
      endcase
    end
  end

  assign bus.CIN   = r_cin;
  assign bus.CADDR = r_caddr;
  assign bus.CLOAD = r_cload;
  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = r_done;

  a_caddr_step: assert property (@(posedge clk_slow) disable iff (!resetn)
    (r_cload && $past(r_cload)) |-> (r_caddr == $past(r_caddr) + ADDR_W'(1)));

  a_done_not_loading: assert property (@(posedge clk_slow) disable iff (!resetn)
    r_done |-> !r_cload);

endmodule

// File: tb/tb_fir_da_lut_loader.sv
// Scoreboard bench for fir_da_lut_loader: driver pushes expected table entries
// and done cycles; a negedge monitor pops and compares as the DUT emits them.
module tb_fir_da_lut_loader;
  import fir_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LUT_W-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;

  int   n_checks = 0;
  int   n_pass = 0;

  exp_t            exp_q [$];
  int              done_q [$];
  logic [LUT_W-1:0] spot [int];
  int              m_coef [NTAPS];

  exp_t            mon_e;
  int              mon_d;

  fir_da_lut_loader_if bus ();

  fir_da_lut_loader dut (
    .clk_slow (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (bus.CLOAD) begin
        check(exp_q.size() > 0, "cload_expected", bus.CADDR, -1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check(bus.CADDR == mon_e.addr, "caddr", bus.CADDR, mon_e.addr);
          check(bus.CIN == mon_e.data, "cin", bus.CIN, mon_e.data);
          if (spot.exists(int'(mon_e.addr)))
            check(bus.CIN == spot[int'(mon_e.addr)], "spot_cin", bus.CIN, spot[int'(mon_e.addr)]);
        end
      end
      if (bus.done) begin
        check(done_q.size() > 0, "done_expected", cyc, -1);
        if (done_q.size() > 0) begin
          mon_d = done_q.pop_front();
          check(cyc == mon_d, "done_cycle", cyc, mon_d);
          check(!bus.CLOAD && bus.busy, "done_flags", {bus.CLOAD, bus.busy}, 1);
        end
      end
    end
  end

  task automatic push_run();
    for (int a = 0; a < LUT_DEPTH; a++) begin
      int s = 0;
      int g = a / 256;
      for (int b = 0; b < GRP; b++) begin
        if (((a >> b) & 1) == 1) s += m_coef[g * GRP + b];
      end
      exp_q.push_back('{addr: ADDR_W'(a), data: LUT_W'(s)});
    end
  endtask

  task automatic write_coef(input int a, input int d);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = COEF_AW'(a);
    bus.coef_in   = COEF_W'(d);
    m_coef[a] = d;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    bit seen = 0;
    for (int i = 0; i < 2200 && !seen; i++) begin
      @(negedge clk);
      if (!bus.busy) seen = 1;
    end
    check(seen && (cyc == n + 2050), "busy_fall_cycle", cyc, n + 2050);
  endtask

  task automatic run_once(input bit disturb);
    int n;
    @(negedge clk);
    push_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    done_q.push_back(n + 2049);
    @(negedge clk);
    bus.start = 1'b0;
    check(bus.busy == 1'b1, "busy_after_start", bus.busy, 1);
    if (disturb) begin
      repeat (500) @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = '0;
      bus.coef_in   = COEF_W'(5);
      bus.start     = 1'b1;
      @(negedge clk);
      bus.coef_we = 1'b0;
      bus.start   = 1'b0;
    end
    wait_idle(n);
  endtask

  task automatic run_b2b();
    int n;
    @(negedge clk);
    push_run();
    push_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    done_q.push_back(n + 2049);
    done_q.push_back(n + 2051 + 2049);
    repeat (2050) @(posedge clk);
    @(negedge clk);
    check(bus.busy == 1'b0, "b2b_idle_gap", bus.busy, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check(bus.busy == 1'b1, "b2b_second_accept", bus.busy, 1);
    wait_idle(n + 2051);
  endtask

  task automatic reset_mid_run();
    int n;
    bit hit = 0;
    @(negedge clk);
    push_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2100 && !hit; i++) begin
      @(negedge clk);
      if (bus.CLOAD && bus.CADDR == ADDR_W'(1000)) hit = 1;
    end
    check(hit, "reached_entry_1000", bus.CADDR, 1000);
    #2 resetn = 1'b0;
    #1;
    check(bus.CLOAD == 1'b0, "rst_mid_cload", bus.CLOAD, 0);
    check(bus.busy == 1'b0, "rst_mid_busy", bus.busy, 0);
    check(bus.done == 1'b0, "rst_mid_done", bus.done, 0);
    check(bus.CIN == '0, "rst_mid_cin", bus.CIN, 0);
    exp_q.delete();
    for (int k = 0; k < NTAPS; k++) m_coef[k] = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check(bus.busy == 1'b0 && bus.done == 1'b0, "post_rst_idle", {bus.busy, bus.done}, 0);
  endtask

  initial begin
    #(10 * 45000);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_in   = '0;
    bus.start     = 1'b0;
    for (int k = 0; k < NTAPS; k++) m_coef[k] = 0;

    repeat (3) @(negedge clk);
    check(bus.CIN == '0, "reset_cin", bus.CIN, 0);
    check(bus.CADDR == '0, "reset_caddr", bus.CADDR, 0);
    check(bus.CLOAD == 1'b0, "reset_cload", bus.CLOAD, 0);
    check(bus.busy == 1'b0, "reset_busy", bus.busy, 0);
    check(bus.done == 1'b0, "reset_done", bus.done, 0);
    resetn = 1'b1;
    @(negedge clk);

    run_once(1'b0);

    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    spot[32'h0FF] = 20'd36;
    spot[32'h1FF] = 20'd100;
    spot[32'h703] = 20'd115;
    spot[32'h500] = 20'd0;
    run_once(1'b1);
    spot.delete();

    spot[32'h001] = 20'd1;
    run_once(1'b0);
    spot.delete();

    for (int k = 0; k < NTAPS; k++) write_coef(k, 32'hFFFF);
    spot[32'h7FF] = 20'h7FFF8;
    run_once(1'b0);
    spot.delete();

    reset_mid_run();
    spot[32'h7FF] = 20'd0;
    run_once(1'b0);
    spot.delete();

    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 65535)));
      run_b2b();
    end

    repeat (4) @(negedge clk);
    check(exp_q.size() == 0, "entries_drained", exp_q.size(), 0);
    check(done_q.size() == 0, "dones_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
